spi_master_byte: RTL
====================

# spi_master_byte

Byte-level SPI master that sits directly downstream of the flash command sequencer. It takes one byte per `wr_req`/`wr_ack` handshake, shifts it out on MOSI while shifting a byte in from MISO, and returns the received byte in the same handshake. It also drives the flash chip-select from the sequencer's CS request and generates DCLK from `sys_clk`.

## Interface
- `CLK_DIV`, 2: half-period of DCLK in `sys_clk` cycles. Range 1..65535; a 16-bit counter.
- `CPOL`, 0: DCLK idle level.
- `CPHA`, 0: 0 = sample on the first DCLK edge of each bit; 1 = sample on the second edge.

- `sys_clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `CS_reg`  in  1  chip-select request from the sequencer (0 = select).
- `wr_req`  in  1  level request: transfer the byte on `send_data`.
- `send_data`  in  8  byte to transmit, MSB first.
- `wr_ack`  out  1  one-cycle pulse when a byte completes.
- `data_recv`  out  8  received byte; valid in the `wr_ack` cycle and held until the next `wr_ack`.
- `nCS`  out  1  flash chip select; registered copy of `CS_reg`.
- `DCLK`  out  1  SPI clock.
- `MOSI`  out  1  serial data out.
- `MISO`  in  1  serial data in.

## Operation
- Reset values: `wr_ack`=0, `data_recv`=0x00, `nCS`=1, `DCLK`=CPOL, `MOSI`=0, state IDLE, counters 0.
- FSM states are IDLE, LOAD, SHIFT, ACK and GUARD.
- IDLE: `DCLK`=CPOL and `MOSI`=0. If `wr_req`=1, go to LOAD; otherwise stay.
- LOAD (1 cycle):
  - Latch `send_data` into the TX shift register.
  - Clear the edge counter (0..15) and the divider counter.
  - If CPHA=0, drive `MOSI`=`send_data[7]` from this cycle.
  - Go to SHIFT.
- SHIFT:
  - The divider counts 0..CLK_DIV-1; on terminal count, toggle DCLK and increment the edge counter.
  - Leading edges (even count): CPHA=0 samples `MISO` into the RX shift register LSB; CPHA=1 shifts the next TX bit onto `MOSI`.
  - Trailing edges (odd count): CPHA=0 shifts the next TX bit onto `MOSI`; CPHA=1 samples `MISO`.
  - After the 16th edge, DCLK is back at CPOL; go to ACK.
- ACK (1 cycle): `wr_ack`=1 and `data_recv` = the assembled RX byte (MSB = first bit received). Go to GUARD.
- GUARD (1 cycle): no action; go to IDLE. This gives the sequencer's registered `byte_cnt`, `send_data` and `wr_req` two cycles to update before IDLE samples them again.
- `nCS` <= `CS_reg` every cycle, independent of the FSM.
- Once LOAD is entered, the byte always completes:
  - `wr_req` falling mid-byte is ignored and still gets one `wr_ack`.
  - `CS_reg` changing mid-byte changes `nCS` but does not abort the shift.
- `send_data` changes outside LOAD are ignored.
- Reset asserted mid-byte: every output returns to its reset value at once. No `wr_ack` is issued for the partial byte.
- `MISO` is sampled in the `sys_clk` cycle in which the sampling DCLK edge is registered, with no extra synchronizer. The flash output is timed to DCLK, so this is safe for CLK_DIV≥1.

## Timing
- Let L be the cycle LOAD is occupied.
- DCLK edge k (k=1..16) is registered at the end of cycle L + k·CLK_DIV.
- `wr_ack` is high in cycle L + 1 + 16·CLK_DIV, which is L+33 for CLK_DIV=2.
- With `wr_req` held high, the byte-to-byte period is 16·CLK_DIV + 4 cycles (IDLE, LOAD, shift, ACK, GUARD): 36 for CLK_DIV=2, 20 for CLK_DIV=1.
- Latency from `wr_req` rising (seen in IDLE) to `wr_ack` is 2 + 16·CLK_DIV cycles.
- The sequencer drops `wr_req` two cycles after the final `wr_ack`, i.e. exactly when this block is back in IDLE, so no spurious extra byte starts.
- `nCS` lags `CS_reg` by 1 cycle.

## Test plan
- Mode 0, CLK_DIV=2, send 0xA5, MISO model returns 0x3C:
  - MOSI bits 1,0,1,0,0,1,0,1 are stable at each rising DCLK.
  - `wr_ack` pulses once at L+33 with `data_recv`=0x3C.
  - DCLK ends low.
- Back-to-back bytes 0x03, 0x12, 0x34, 0x56 with `wr_req` held high and the sequencer model updating `send_data` one cycle after each ack:
  - 4 acks spaced exactly 36 cycles apart.
  - MOSI stream matches the bytes; no fifth byte.
- Mode 3 (CPOL=1, CPHA=1), CLK_DIV=1, send 0x9F, MISO returns 0xEF:
  - DCLK idles high; MOSI changes on falling edges and MISO is sampled on rising edges.
  - `data_recv`=0xEF at L+17.
- `wr_req` deasserted 5 cycles after LOAD: the byte completes, exactly one `wr_ack`, then IDLE with DCLK=CPOL and MOSI=0.
- `rst_n` low in the middle of SHIFT (edge 7):
  - Outputs immediately at reset values: DCLK=CPOL, MOSI=0, nCS=1, wr_ack=0, data_recv=0x00.
  - After release, a new 0x55 transfer completes correctly.
- `CS_reg` toggled 1→0→1: `nCS` follows with a 1-cycle lag in IDLE and mid-byte, and the shift is never disturbed.

Source files
------------

// File: rtl/spi_master_byte.sv
// Byte-wide SPI master: one byte per wr_req/wr_ack exchange, full duplex,
// with DCLK derived from sys_clk and nCS as a registered copy of CS_reg.
module spi_master_byte #(
  parameter logic [15:0] CLK_DIV = 16'd2,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       CS_reg,
  input  logic       wr_req,
  input  logic [7:0] send_data,
  output logic       wr_ack,
  output logic [7:0] data_recv,
  output logic       nCS,
  output logic       DCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic [2:0] dbg_state
);

  // Handshake: wr_req is a level request sampled only in IDLE; once a byte is
  // accepted it always runs to completion and wr_ack pulses for exactly one
  // cycle with data_recv valid in that cycle (held until the next wr_ack).
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    ACK   = 3'd3,
    GUARD = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = CLK_DIV - 16'd1;

  state_t      state;
  logic [15:0] div_cnt;
  logic [3:0]  edge_cnt;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_next;

  assign rx_next   = {rx_sr[6:0], MISO};
  assign dbg_state = state;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= 16'd0;
      edge_cnt  <= 4'd0;
      tx_sr     <= 8'd0;
      rx_sr     <= 8'd0;
      wr_ack    <= 1'b0;
      data_recv <= 8'd0;
      DCLK      <= CPOL;
      MOSI      <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          DCLK <= CPOL;
          MOSI <= 1'b0;
          if (wr_req) state <= LOAD;
        end
        LOAD: begin
          div_cnt  <= 16'd0;
          edge_cnt <= 4'd0;
          // CPHA=0 needs bit 7 on the line before the first (sampling) edge
          if (!CPHA) begin
            MOSI  <= send_data[7];
            tx_sr <= {send_data[6:0], 1'b0};
          end else begin
            tx_sr <= send_data;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 16'd0;
            DCLK     <= ~DCLK;
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt[0] == CPHA) begin
              rx_sr <= rx_next;
            end else begin
              MOSI  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
            // the 16th edge may itself be a sample edge (CPHA=1)
            if (edge_cnt == 4'd15) begin
              wr_ack    <= 1'b1;
              data_recv <= CPHA ? rx_next : rx_sr;
              state     <= ACK;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        ACK: begin
          MOSI  <= 1'b0;
          state <= GUARD;
        end
        GUARD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) nCS <= 1'b1;
    else        nCS <= CS_reg;
  end

endmodule
